layer_sequencer: RTL

Walks a configured network layer by layer, neuron by neuron, input by input, and drives the `main_memory` weight/bias fetch port (`weight_en`, `bias_en`, `n`, `i`). It pauses for engine backpressure and hands each finished neuron to the CORDIC activation stage. It sits between the top-level configuration inputs and the memory/engine pair, and owns all index generation so the engine holds only the MAC/activation datapath.

---
 rtl/nn_seq_pkg.sv | 23 ++
 rtl/layer_cfg_select.sv | 85 ++++++++
 rtl/layer_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/nn_seq_pkg.sv
// rtl/nn_seq_pkg.sv - shared sequencer types, sizing constants and activation codes
package nn_seq_pkg;

    localparam int MAX_LAYERS = 5;
    localparam int IDX_W      = 6;
    localparam int AF_W       = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIAS,
        ST_WEIGHT,
        ST_ACT_GO,
        ST_ACT_WAIT,
        ST_DONE
    } seq_state_t;

    // Activation selects, decoded identically by the CORDIC activation stage
    localparam logic [AF_W-1:0] AF_RELU    = 2'd0;
    localparam logic [AF_W-1:0] AF_SIGMOID = 2'd1;
    localparam logic [AF_W-1:0] AF_TANH    = 2'd2;
    localparam logic [AF_W-1:0] AF_LINEAR  = 2'd3;

endpackage

// File: rtl/layer_cfg_select.sv
// rtl/layer_cfg_select.sv - latches network configuration and selects per-layer sizes
// Ports: clk/rst_n, load (capture config), raw config inputs, layer index;
//        cfg_ok (raw config acceptable), num_layers, fan_in, neurons, af_sel.
module layer_cfg_select
    import nn_seq_pkg::*;
#(
    parameter int MAX_LAYERS = nn_seq_pkg::MAX_LAYERS,
    parameter int IDX_W      = nn_seq_pkg::IDX_W,
    parameter int AF_W       = nn_seq_pkg::AF_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [IDX_W-1:0] no_layers,
    input  logic [IDX_W-1:0] n_inputs,
    input  logic [IDX_W-1:0] nl1,
    input  logic [IDX_W-1:0] nl2,
    input  logic [IDX_W-1:0] nl3,
    input  logic [IDX_W-1:0] nl4,
    input  logic [IDX_W-1:0] nl5,
    input  logic [AF_W-1:0]  afl1,
    input  logic [AF_W-1:0]  afl2,
    input  logic [AF_W-1:0]  afl3,
    input  logic [AF_W-1:0]  afl4,
    input  logic [AF_W-1:0]  afl5,
    input  logic [2:0]       layer,
    output logic             cfg_ok,
    output logic [IDX_W-1:0] num_layers,
    output logic [IDX_W-1:0] fan_in,
    output logic [IDX_W-1:0] neurons,
    output logic [AF_W-1:0]  af_sel
);

    logic [IDX_W-1:0] nl_in  [MAX_LAYERS];
    logic [AF_W-1:0]  afl_in [MAX_LAYERS];
    logic [IDX_W-1:0] nl_q   [MAX_LAYERS];
    logic [AF_W-1:0]  afl_q  [MAX_LAYERS];
    logic [IDX_W-1:0] n_inputs_q;

    assign nl_in[0]  = nl1;
    assign nl_in[1]  = nl2;
    assign nl_in[2]  = nl3;
    assign nl_in[3]  = nl4;
    assign nl_in[4]  = nl5;
    assign afl_in[0] = afl1;
    assign afl_in[1] = afl2;
    assign afl_in[2] = afl3;
    assign afl_in[3] = afl4;
    assign afl_in[4] = afl5;

    // Validity is judged on the raw inputs so the decision is ready in the start cycle;
    // only layers below no_layers need a non-zero neuron count.
    always_comb begin
        cfg_ok = (no_layers != '0) && (no_layers <= IDX_W'(MAX_LAYERS)) && (n_inputs != '0);
        for (int k = 0; k < MAX_LAYERS; k++) begin
            if ((IDX_W'(k) < no_layers) && (nl_in[k] == '0)) begin
                cfg_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_layers <= '0;
            n_inputs_q <= '0;
            for (int k = 0; k < MAX_LAYERS; k++) begin
                nl_q[k]  <= '0;
                afl_q[k] <= '0;
            end
        end else if (load) begin
            num_layers <= no_layers;
            n_inputs_q <= n_inputs;
            for (int k = 0; k < MAX_LAYERS; k++) begin
                nl_q[k]  <= nl_in[k];
                afl_q[k] <= afl_in[k];
            end
        end
    end

    // A layer's fan-in is the neuron count of the layer feeding it
    assign fan_in  = (layer == 3'd0) ? n_inputs_q : nl_q[layer - 3'd1];
    assign neurons = nl_q[layer];
    assign af_sel  = afl_q[layer];

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - layer/neuron/input walker driving weight and bias fetches
// Ports: clk/rst_n, start + configuration (no_layers, n_inputs, nl1..5, afl1..5),
//        engine handshake (eng_ready, act_done); fetch strobes and indices
//        (weight_en, bias_en, n, i, layer), data-aligned valids (wt_valid, bias_valid),
//        act_go, af_sel, busy, done, cfg_err.
module layer_sequencer
    import nn_seq_pkg::*;
#(
    parameter int MAX_LAYERS = nn_seq_pkg::MAX_LAYERS,
    parameter int IDX_W      = nn_seq_pkg::IDX_W,
    parameter int AF_W       = nn_seq_pkg::AF_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] no_layers,
    input  logic [IDX_W-1:0] n_inputs,
    input  logic [IDX_W-1:0] nl1,
    input  logic [IDX_W-1:0] nl2,
    input  logic [IDX_W-1:0] nl3,
    input  logic [IDX_W-1:0] nl4,
    input  logic [IDX_W-1:0] nl5,
    input  logic [AF_W-1:0]  afl1,
    input  logic [AF_W-1:0]  afl2,
    input  logic [AF_W-1:0]  afl3,
    input  logic [AF_W-1:0]  afl4,
    input  logic [AF_W-1:0]  afl5,
    input  logic             eng_ready,
    input  logic             act_done,
    output logic             weight_en,
    output logic             bias_en,
    output logic [IDX_W-1:0] n,
    output logic [IDX_W-1:0] i,
    output logic [2:0]       layer,
    output logic             wt_valid,
    output logic             bias_valid,
    output logic             act_go,
    output logic [AF_W-1:0]  af_sel,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    seq_state_t       state;
    logic             cfg_ok;
    logic             load;
    logic [IDX_W-1:0] num_layers;
    logic [IDX_W-1:0] fan_in;
    logic [IDX_W-1:0] neurons;

    assign load = (state == ST_IDLE) && start;

    layer_cfg_select #(
        .MAX_LAYERS (MAX_LAYERS),
        .IDX_W      (IDX_W),
        .AF_W       (AF_W)
    ) u_cfg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .no_layers  (no_layers),
        .n_inputs   (n_inputs),
        .nl1        (nl1),
        .nl2        (nl2),
        .nl3        (nl3),
        .nl4        (nl4),
        .nl5        (nl5),
        .afl1       (afl1),
        .afl2       (afl2),
        .afl3       (afl3),
        .afl4       (afl4),
        .afl5       (afl5),
        .layer      (layer),
        .cfg_ok     (cfg_ok),
        .num_layers (num_layers),
        .fan_in     (fan_in),
        .neurons    (neurons),
        .af_sel     (af_sel)
    );

    // Strobes follow eng_ready in the same cycle so a stalled cycle never issues a fetch
    assign bias_en   = (state == ST_BIAS)   && eng_ready;
    assign weight_en = (state == ST_WEIGHT) && eng_ready;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            n          <= '0;
            i          <= '0;
            layer      <= '0;
            wt_valid   <= 1'b0;
            bias_valid <= 1'b0;
            act_go     <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            wt_valid   <= weight_en;
            bias_valid <= bias_en;
            act_go     <= 1'b0;
            done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n     <= '0;
                        i     <= '0;
                        layer <= '0;
                        if (cfg_ok) begin
                            cfg_err <= 1'b0;
                            state   <= ST_BIAS;
                        end else begin
                            cfg_err <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_BIAS: begin
                    if (eng_ready) begin
                        state <= ST_WEIGHT;
                    end
                end
                ST_WEIGHT: begin
                    if (eng_ready) begin
                        if (i == fan_in - IDX_W'(1)) begin
                            act_go <= 1'b1;
                            state  <= ST_ACT_GO;
                        end else begin
                            i <= i + IDX_W'(1);
                        end
                    end
                end
                ST_ACT_GO: begin
                    state <= ST_ACT_WAIT;
                end
                ST_ACT_WAIT: begin
                    if (act_done) begin
                        i <= '0;
                        if (n < neurons - IDX_W'(1)) begin
                            n     <= n + IDX_W'(1);
                            state <= ST_BIAS;
                        end else if (IDX_W'(layer) < num_layers - IDX_W'(1)) begin
                            layer <= layer + 3'd1;
                            n     <= '0;
                            state <= ST_BIAS;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Entered with done already set after the last neuron; a rejected
                    // configuration arrives with done clear and spends one extra cycle here.
                    if (done) begin
                        state <= ST_IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
